// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - funct3 encodings (F3_B/H/W/BU/HU), normalisation of undefined codes to W
//   - FSM state enum, latched-request struct
//   - byte-lane mask constants and helpers for lane offset / lane mask
package lsu_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [NUM_LANES-1:0] LM_B = 4'b0001;
  localparam logic [NUM_LANES-1:0] LM_H = 4'b0011;
  localparam logic [NUM_LANES-1:0] LM_W = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LDATA, S_WR, S_RMW_RD, S_RMW_MRG, S_RMW_WR
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;   // normalised
    logic [1:0]  off;      // byte offset within the word
    logic [31:0] wdata;
  } req_t;

  // Undefined encodings (011, 110, 111) act as a full-word access.
  function automatic logic [2:0] norm_f3(input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_BU, F3_HU: return f3;
      default:                  return F3_W;
    endcase
  endfunction

  // Effective byte offset: halfwords ignore addr[0], words ignore addr[1:0].
  function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: return off;
      F3_H, F3_HU: return {off[1], 1'b0};
      default:     return 2'b00;
    endcase
  endfunction

  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: return LM_B << eff_off(f3, off);
      F3_H, F3_HU: return LM_H << eff_off(f3, off);
      default:     return LM_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational data alignment for the LSU.
//   ld_word/funct3/off -> ld_data : extract byte/half/word lane, sign- or zero-extend
//   st_old/st_wdata/funct3/off -> st_word : merge store data into the old word,
//                                           untouched lanes passed through bit-exact
// funct3 is expected already normalised (lsu_pkg::norm_f3).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] st_old,
  input  logic [31:0] st_wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [1:0]                     eoff;
  logic [31:0]                    sh;
  logic [31:0]                    rep;
  logic [NUM_LANES-1:0]           mask;
  logic [NUM_LANES-1:0][7:0]      old_l, rep_l, new_l;

  assign eoff = eff_off(funct3, off);
  assign sh   = ld_word >> {eoff, 3'b000};

  always_comb begin
    ld_data = sh;
    case (funct3)
      F3_B:    ld_data = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   ld_data = {24'h0, sh[7:0]};
      F3_H:    ld_data = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   ld_data = {16'h0, sh[15:0]};
      default: ld_data = sh;
    endcase
  end

  // Replicate store data across all lanes; the mask then picks the live lanes.
  always_comb begin
    rep = st_wdata;
    case (funct3)
      F3_B, F3_BU: rep = {4{st_wdata[7:0]}};
      F3_H, F3_HU: rep = {2{st_wdata[15:0]}};
      default:     rep = st_wdata;
    endcase
  end

  assign mask  = lane_mask(funct3, off);
  assign old_l = st_old;
  assign rep_l = rep;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign new_l[gi] = mask[gi] ? rep_l[gi] : old_l[gi];
  end

  assign st_word = new_l;

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32 memory-stage LSU in front of a word-wide DataMemory.
//   Request side : req_valid/req_ready handshake, req_we, req_funct3, req_addr, req_wdata
//   Response side: resp_valid (1-cycle pulse), resp_rdata, resp_err
//   Memory side  : MEM_EN, MEM_RW (1=write), MEM_ADDR (word), MEM_DIN, MEM_DOUT
//   CLK rising edge; RST synchronous active-high.
// Loads take 2 cycles, SW 1 cycle, SB/SH 3 cycles (read-modify-write).
// All outputs are registered: the comb process computes next-cycle values.
// Build option: `define MISALIGN_TRAP_EN makes misaligned H/HU/W accesses
// return resp_err=1 without touching memory; otherwise low bits are ignored.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 30
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              MEM_EN,
  output logic              MEM_RW,
  output logic [MEM_AW-1:0] MEM_ADDR,
  output logic [31:0]       MEM_DIN,
  input  logic [31:0]       MEM_DOUT
);

  state_t             state, nxt;
  req_t               rq, rq_n;
  logic [31:0]        old_q, old_n;
  logic               n_ready, n_valid, n_err, n_en, n_rw;
  logic [31:0]        n_rdata, n_din;
  logic [MEM_AW-1:0]  n_addr;
  logic [2:0]         f3n;
  logic               mis;
  logic [31:0]        ld_data, st_word;

  lsu_align u_align (
    .ld_word  (MEM_DOUT),
    .funct3   (rq.funct3),
    .off      (rq.off),
    .st_old   (old_q),
    .st_wdata (rq.wdata),
    .ld_data  (ld_data),
    .st_word  (st_word)
  );

  assign f3n = norm_f3(req_funct3);

  always_comb begin
    mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = ((f3n == F3_H || f3n == F3_HU) && req_addr[0]) ||
          ((f3n == F3_W) && (req_addr[1:0] != 2'b00));
`endif
  end

  always_comb begin
    nxt     = state;
    rq_n    = rq;
    old_n   = old_q;
    n_ready = 1'b0;
    n_valid = 1'b0;
    n_rdata = 32'h0;
    n_err   = 1'b0;
    n_en    = 1'b0;
    n_rw    = 1'b0;
    n_addr  = MEM_ADDR;
    n_din   = MEM_DIN;
    case (state)
      S_IDLE: begin
        n_ready = 1'b1;
        if (req_valid && req_ready) begin
          n_ready = 1'b0;
          rq_n    = '{we: req_we, funct3: f3n, off: req_addr[1:0], wdata: req_wdata};
          if (mis) begin
            // error response straight away, memory untouched
            nxt     = S_LDATA;
            n_valid = 1'b1;
            n_err   = 1'b1;
          end else begin
            n_en   = 1'b1;
            n_addr = req_addr[MEM_AW+1:2];
            if (!req_we) begin
              nxt = S_RD;
            end else if (f3n == F3_W) begin
              nxt     = S_WR;
              n_rw    = 1'b1;
              n_din   = req_wdata;
              n_valid = 1'b1;
            end else begin
              nxt = S_RMW_RD;
            end
          end
        end
      end
      S_RD: begin
        nxt     = S_LDATA;
        n_valid = 1'b1;
        n_rdata = ld_data;
      end
      S_LDATA, S_WR, S_RMW_WR: begin
        nxt     = S_IDLE;
        n_ready = 1'b1;
      end
      S_RMW_RD: begin
        nxt   = S_RMW_MRG;
        old_n = MEM_DOUT;
      end
      S_RMW_MRG: begin
        nxt     = S_RMW_WR;
        n_en    = 1'b1;
        n_rw    = 1'b1;
        n_din   = st_word;
        n_valid = 1'b1;
      end
      default: begin
        nxt     = S_IDLE;
        n_ready = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      rq         <= '0;
      old_q      <= 32'h0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      MEM_EN     <= 1'b0;
      MEM_RW     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_DIN    <= 32'h0;
    end else begin
      state      <= nxt;
      rq         <= rq_n;
      old_q      <= old_n;
      req_ready  <= n_ready;
      resp_valid <= n_valid;
      resp_rdata <= n_rdata;
      resp_err   <= n_err;
      MEM_EN     <= n_en;
      MEM_RW     <= n_rw;
      MEM_ADDR   <= n_addr;
      MEM_DIN    <= n_din;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised scoreboard bench for load_store_unit with a word-wide DataMemory
// model (read data presented combinationally from MEM_ADDR, writes at the edge).
// A byte-level reference memory predicts every response and its cycle.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        MEM_EN, MEM_RW;
  logic [29:0] MEM_ADDR;
  logic [31:0] MEM_DIN, MEM_DOUT;

  load_store_unit #(.MEM_AW(30)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MEM_EN(MEM_EN), .MEM_RW(MEM_RW), .MEM_ADDR(MEM_ADDR),
    .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT)
  );

  always #5 CLK = ~CLK;

  // DataMemory model, 64 words
  logic [31:0] mem  [64];
  logic [31:0] refm [64];
  logic        do_init = 1'b1;
  assign MEM_DOUT = mem[MEM_ADDR[5:0]];
  always @(posedge CLK) begin
    if (do_init) for (int i = 0; i < 64; i++) mem[i] <= refm[i];
    else if (MEM_EN && MEM_RW) mem[MEM_ADDR[5:0]] <= MEM_DIN;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  typedef struct { logic [31:0] rdata; logic err; int cyc; } exp_t;
  exp_t q[$];
  exp_t me;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain byte arithmetic on the reference memory.
  function automatic void ref_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, output logic [31:0] rd,
                                 output logic err, output int lat);
    int f, w, b, h;
    logic [31:0] word, v;
    f = (f3 == 3 || f3 == 6 || f3 == 7) ? 2 : int'(f3);
    w = (a / 4) % 64;
    b = a % 4;
    h = (a / 2) % 2;
    word = refm[w];
    rd = 0; err = 0; lat = 0;
`ifdef MISALIGN_TRAP_EN
    if (((f == 1 || f == 5) && (a % 2 == 1)) || (f == 2 && b != 0)) begin
      err = 1; lat = 1; return;
    end
`endif
    if (!we) begin
      lat = 2;
      if (f == 0 || f == 4) begin
        v = (word >> (8 * b)) & 32'hFF;
        if (f == 0 && v >= 128) v = v | 32'hFFFFFF00;
      end else if (f == 1 || f == 5) begin
        v = (word >> (16 * h)) & 32'hFFFF;
        if (f == 1 && v >= 32768) v = v | 32'hFFFF0000;
      end else v = word;
      rd = v;
    end else if (f == 2) begin
      lat = 1;
      refm[w] = wd;
    end else if (f == 0) begin
      lat = 3;
      refm[w] = (word & ~(32'hFF << (8 * b))) | ((wd & 32'hFF) << (8 * b));
    end else begin
      lat = 3;
      refm[w] = (word & ~(32'hFFFF << (16 * h))) | ((wd & 32'hFFFF) << (16 * h));
    end
  endfunction

  // Monitor: every response must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (resp_valid) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_resp: got rdata %h err %b, expected no response", resp_rdata, resp_err);
      end else begin
        me = q.pop_front();
        chk("resp_rdata", resp_rdata, me.rdata);
        chk("resp_err", {31'h0, resp_err}, {31'h0, me.err});
        chk("resp_cycle", cyc, me.cyc);
      end
    end
  end

  // Waits for req_ready (driving ignored junk meanwhile), presents one request.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int waited = 0;
    exp_t e;
    logic [31:0] rd;
    logic er;
    int lat;
    @(negedge CLK);
    while (!req_ready) begin
      if (waited++ > 40) begin
        n_cmp++; n_bad++;
        $display("FAIL req_ready_timeout: got ready=0 after %0d cycles, expected ready=1", waited);
        req_valid = 1'b0;
        return;
      end
      req_valid = 1'b1; req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      @(negedge CLK);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    ref_op(we, f3, a, wd, rd, er, lat);
    e.rdata = rd; e.err = er; e.cyc = cyc + lat;
    q.push_back(e);
    @(posedge CLK);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [2:0]  st_tab [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
  logic [31:0] saved;
  logic        rwe;
  logic [2:0]  rf3;
  int          drain;

  initial begin
    for (int i = 0; i < 64; i++) refm[i] = $urandom;
    refm[3] = 32'h8899AABB;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_mem_en", {31'h0, MEM_EN}, 32'h0);
    chk("rst_mem_rw", {31'h0, MEM_RW}, 32'h0);
    chk("rst_mem_addr", {2'b0, MEM_ADDR}, 32'h0);
    chk("rst_mem_din", MEM_DIN, 32'h0);
    @(posedge CLK);
    #1 RST = 1'b0; do_init = 1'b0;

    // LW 0x0C: read command in cycle 1
    issue(1'b0, 3'b010, 32'h0C, 32'h0);
    chk("lw_mem_en", {31'h0, MEM_EN}, 32'h1);
    chk("lw_mem_rw", {31'h0, MEM_RW}, 32'h0);
    chk("lw_mem_addr", {2'b0, MEM_ADDR}, 32'h3);
    issue(1'b0, 3'b000, 32'h0D, 32'h0);
    issue(1'b0, 3'b100, 32'h0D, 32'h0);
    issue(1'b0, 3'b101, 32'h0E, 32'h0);
    issue(1'b0, 3'b010, 32'h0D, 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_no_mem_en", {31'h0, MEM_EN}, 32'h0);
`endif

    // SB aborted by reset while merging: no write, pending response dropped
    saved = refm[3];
    issue(1'b1, 3'b000, 32'h0C, 32'h55);
    @(posedge CLK);
    #1 RST = 1'b1; q.delete(); refm[3] = saved;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_abort_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_abort_word3", mem[3], 32'h8899AABB);

    // SH 0x1234 at 0x0E: merged word written in cycle 3
    issue(1'b1, 3'b001, 32'h0E, 32'h00001234);
    @(posedge CLK); @(posedge CLK); #1;
    chk("sh_mem_en", {31'h0, MEM_EN}, 32'h1);
    chk("sh_mem_rw", {31'h0, MEM_RW}, 32'h1);
    chk("sh_mem_din", MEM_DIN, 32'h1234AABB);

    // SW then LW readback
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("sw_mem_en", {31'h0, MEM_EN}, 32'h1);
    chk("sw_mem_rw", {31'h0, MEM_RW}, 32'h1);
    chk("sw_mem_addr", {2'b0, MEM_ADDR}, 32'h4);
    issue(1'b0, 3'b010, 32'h10, 32'h0);

    // random mix
    repeat (300) begin
      rwe = 1'($urandom_range(0, 1));
      rf3 = rwe ? st_tab[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      issue(rwe, rf3, 32'($urandom_range(0, 255)), $urandom);
    end

    drain = 0;
    while (q.size() > 0 && drain < 20) begin @(negedge CLK); drain++; end
    chk("scoreboard_drained", q.size(), 32'h0);
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("mem_word_%0d", i), mem[i], refm[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
